// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_clear_ctrl
// Purpose  : Removes full rows from the saved playfield after a piece locks,
//            writes the compacted field back and keeps a cleared-line score.
// Revision : 1.0 - initial release
// ============================================================================
module line_clear_ctrl #(
   parameter int COLS = 10,
   parameter int ROWS = 24
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Pause,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] state_in,
   input  logic                 score_clear,
   output logic                 busy,
   output logic [ROWS*COLS-1:0] state_out,
   output logic                 load_out,
   output logic                 done,
   output logic [4:0]           lines_cleared,
   output logic [15:0]          score
);

   localparam int c_W = ROWS * COLS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_SHIFT = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [c_W-1:0] r_field, w_field_nxt, w_shifted;
   logic [c_W-1:0] r_state_out, w_state_out_nxt, w_fin_field;
   logic [4:0]     r_row, w_row_nxt, w_row_up;
   logic [4:0]     r_k, w_k_nxt, w_fin_k;
   logic [4:0]     r_lines, w_lines_nxt;
   logic           r_busy, w_busy_nxt;
   logic           r_load, w_load_nxt;
   logic           r_done, w_done_nxt;
   logic [15:0]    r_score, w_score_nxt;
   logic [16:0]    w_sum;
   logic           w_cur_full, w_up_full, w_fin;

   assign w_row_up   = (r_row == 5'd0) ? 5'd0 : r_row - 5'd1;
   assign w_cur_full = &r_field[r_row*COLS +: COLS];
   assign w_up_full  = (r_row != 5'd0) && (&r_field[w_row_up*COLS +: COLS]);

   // Rows row..1 take the row above them; row 0 is refilled empty
   generate
      for (genvar i = 0; i < ROWS; i++) begin : g_shift
         if (i == 0) begin : g_top
            assign w_shifted[0 +: COLS] = '0;
         end else begin : g_body
            assign w_shifted[i*COLS +: COLS] = (i <= int'(r_row)) ?
                   r_field[(i-1)*COLS +: COLS] : r_field[i*COLS +: COLS];
         end
      end
   endgenerate

   assign w_sum = {1'b0, r_score} + {12'd0, w_fin_k};

   always_comb begin
      w_state_nxt     = r_state;
      w_field_nxt     = r_field;
      w_row_nxt       = r_row;
      w_k_nxt         = r_k;
      w_busy_nxt      = r_busy;
      w_load_nxt      = r_load;
      w_done_nxt      = r_done;
      w_state_out_nxt = r_state_out;
      w_lines_nxt     = r_lines;
      w_score_nxt     = r_score;
      w_fin           = 1'b0;
      w_fin_k         = r_k;
      w_fin_field     = r_field;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_field_nxt = state_in;
               w_row_nxt   = 5'(ROWS - 1);
               w_k_nxt     = 5'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_cur_full) begin
               w_state_nxt = S_SHIFT;
            end else if (r_row == 5'd0) begin
               w_fin = 1'b1;
            end else begin
               w_row_nxt = r_row - 5'd1;
            end
         end
         S_SHIFT: begin
            // The incoming row is tested here so an empty row costs no extra scan cycle
            w_field_nxt = w_shifted;
            w_k_nxt     = r_k + 5'd1;
            if (r_row == 5'd0) begin
               w_fin       = 1'b1;
               w_fin_k     = r_k + 5'd1;
               w_fin_field = w_shifted;
            end else if (!w_up_full) begin
               w_row_nxt   = r_row - 5'd1;
               w_state_nxt = S_SCAN;
            end
         end
         S_WRITE: begin
            w_load_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_fin) begin
         w_state_out_nxt = w_fin_field;
         w_lines_nxt     = w_fin_k;
         w_load_nxt      = 1'b1;
         w_done_nxt      = 1'b1;
         w_score_nxt     = w_sum[16] ? 16'hFFFF : w_sum[15:0];
         w_state_nxt     = S_WRITE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_field     <= '0;
         r_row       <= 5'd0;
         r_k         <= 5'd0;
         r_busy      <= 1'b0;
         r_load      <= 1'b0;
         r_done      <= 1'b0;
         r_state_out <= '0;
         r_lines     <= 5'd0;
      end else if (!Pause) begin
         r_state     <= w_state_nxt;
         r_field     <= w_field_nxt;
         r_row       <= w_row_nxt;
         r_k         <= w_k_nxt;
         r_busy      <= w_busy_nxt;
         r_load      <= w_load_nxt;
         r_done      <= w_done_nxt;
         r_state_out <= w_state_out_nxt;
         r_lines     <= w_lines_nxt;
      end
   end

   // score_clear overrides Pause and any coincident completion
   always_ff @(posedge Clk) begin
      if (Reset || score_clear) begin
         r_score <= 16'd0;
      end else if (!Pause) begin
         r_score <= w_score_nxt;
      end
   end

   assign busy          = r_busy;
   assign state_out     = r_state_out;
   assign load_out      = r_load;
   assign done          = r_done;
   assign lines_cleared = r_lines;
   assign score         = r_score;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_clear_ctrl
// Purpose  : Directed self-checking bench for line_clear_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_clear_ctrl;

   localparam int c_COLS = 10;
   localparam int c_ROWS = 24;
   localparam int c_W    = c_COLS * c_ROWS;

   logic           Clk = 1'b0;
   logic           Reset = 1'b1;
   logic           Pause = 1'b0;
   logic           start = 1'b0;
   logic [c_W-1:0] state_in = '0;
   logic           score_clear = 1'b0;
   logic           busy;
   logic [c_W-1:0] state_out;
   logic           load_out;
   logic           done;
   logic [4:0]     lines_cleared;
   logic [15:0]    score;

   int total = 0;
   int bad   = 0;

   line_clear_ctrl #(.COLS(c_COLS), .ROWS(c_ROWS)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Pause        (Pause),
      .start        (start),
      .state_in     (state_in),
      .score_clear  (score_clear),
      .busy         (busy),
      .state_out    (state_out),
      .load_out     (load_out),
      .done         (done),
      .lines_cleared(lines_cleared),
      .score        (score)
   );

   always #10 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [c_W-1:0] put_row(input logic [c_W-1:0] f, input int r, input logic [9:0] v);
      logic [c_W-1:0] t;
      t = f;
      t[r*c_COLS +: c_COLS] = v;
      return t;
   endfunction

   // Accepts a pass at edge 0 and returns the edge after which done is first seen
   task automatic run_pass(input logic [c_W-1:0] f, output int done_edge);
      state_in = f;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", busy); end
      done_edge = -1;
      for (int e = 1; e <= 80; e++) begin
         tick();
         if (done === 1'b1) begin done_edge = e; break; end
      end
   endtask

   task automatic check_pass(input string nm, input int de, input int exp_edge, input logic [c_W-1:0] exp_f,
                             input logic [4:0] exp_l, input logic [15:0] exp_s);
      total++;
      if (de != exp_edge) begin bad++; $display("FAIL %s_edge got=%0d want=%0d", nm, de, exp_edge); end
      total++;
      if (load_out !== 1'b1) begin bad++; $display("FAIL %s_load got=%b want=1", nm, load_out); end
      total++;
      if (state_out !== exp_f) begin bad++; $display("FAIL %s_field got=%h want=%h", nm, state_out, exp_f); end
      total++;
      if (lines_cleared !== exp_l) begin bad++; $display("FAIL %s_lines got=%0d want=%0d", nm, lines_cleared, exp_l); end
      total++;
      if (score !== exp_s) begin bad++; $display("FAIL %s_score got=%h want=%h", nm, score, exp_s); end
      tick();
      total++;
      if (busy !== 1'b0 || load_out !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL %s_end got=%b%b%b want=000", nm, busy, load_out, done);
      end
      total++;
      if (state_out !== exp_f) begin bad++; $display("FAIL %s_hold got=%h want=%h", nm, state_out, exp_f); end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      total++;
      if (busy !== 1'b0 || load_out !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_ctl got=%b%b%b want=000", busy, load_out, done);
      end
      total++;
      if (state_out !== '0) begin bad++; $display("FAIL reset_field got=%h want=0", state_out); end
      total++;
      if (lines_cleared !== 5'd0 || score !== 16'd0) begin
         bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", lines_cleared, score);
      end
   endtask

   task automatic test_empty();
      int de;
      run_pass('0, de);
      check_pass("empty", de, 24, '0, 5'd0, 16'd0);
   endtask

   task automatic test_one_row();
      int de;
      logic [c_W-1:0] f, x;
      f = put_row('0, 23, 10'h3FF);
      f = put_row(f, 22, 10'b0000000001);
      x = put_row('0, 23, 10'b0000000001);
      run_pass(f, de);
      check_pass("one_row", de, 25, x, 5'd1, 16'd1);
   endtask

   task automatic test_two_rows();
      int de;
      logic [c_W-1:0] f, x;
      f = put_row('0, 23, 10'h3FF);
      f = put_row(f, 22, 10'h155);
      f = put_row(f, 21, 10'h3FF);
      f = put_row(f, 20, 10'h2AA);
      x = put_row('0, 23, 10'h155);
      x = put_row(x, 22, 10'h2AA);
      run_pass(f, de);
      check_pass("two_rows", de, 26, x, 5'd2, 16'd3);
   endtask

   task automatic test_saturate();
      int de;
      logic [c_W-1:0] f;
      f = '0;
      for (int r = 20; r < 24; r++) f = put_row(f, r, 10'h3FF);
      force dut.r_score = 16'hFFFD;
      tick();
      release dut.r_score;
      run_pass(f, de);
      check_pass("saturate", de, 28, '0, 5'd4, 16'hFFFF);
   endtask

   task automatic test_extra_start_and_reset();
      int de;
      bit seen;
      logic [c_W-1:0] full;
      full = '1;
      state_in = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      state_in = full;
      de = -1;
      for (int e = 1; e <= 80; e++) begin
         start = (e == 5);
         tick();
         if (done === 1'b1) begin de = e; break; end
      end
      start = 1'b0;
      check_pass("extra_start", de, 24, '0, 5'd0, 16'hFFFF);
      state_in = put_row('0, 23, 10'h3FF);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 9; e++) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      total++;
      if (busy !== 1'b0 || load_out !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL midreset_ctl got=%b%b%b want=000", busy, load_out, done);
      end
      total++;
      if (score !== 16'd0 || lines_cleared !== 5'd0) begin
         bad++; $display("FAIL midreset_cnt got=%h/%0d want=0/0", score, lines_cleared);
      end
      seen = 1'b0;
      for (int e = 0; e < 40; e++) begin
         tick();
         if (load_out === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL midreset_wb got=1 want=0"); end
   endtask

   task automatic test_pause_clear();
      int de;
      logic [c_W-1:0] f, x;
      f = put_row('0, 23, 10'h3FF);
      f = put_row(f, 22, 10'b0000000001);
      x = put_row('0, 23, 10'b0000000001);
      run_pass(f, de);
      check_pass("pre_pause", de, 25, x, 5'd1, 16'd1);
      state_in = f;
      start = 1'b1;
      tick();
      start = 1'b0;
      state_in = '0;
      de = -1;
      for (int e = 1; e <= 80; e++) begin
         Pause = (e >= 11 && e <= 17);
         score_clear = (e == 32);
         tick();
         if (done === 1'b1) begin de = e; break; end
      end
      Pause = 1'b0;
      score_clear = 1'b0;
      check_pass("pause_clear", de, 32, x, 5'd1, 16'd0);
   endtask

   initial begin
      test_reset();
      test_empty();
      test_one_row();
      test_two_rows();
      test_saturate();
      test_extra_start_and_reset();
      test_pause_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
